lfsr_rng: RTL and testbench

- Parametrised Galois LFSR pseudo-random generator. Successor to the fixed 8-bit seed/load LFSR.
- Adds configurable width and taps, a step enable, and zero-lockup protection.
- Adds a request/valid draw port that returns uniform values in [0, range) by rejection sampling.
- Game logic uses it for spawn positions and produce types. Free-running `q` remains available for raw use.

---
 rtl/lfsr_pkg.sv | 22 ++
 rtl/lfsr_rng_if.sv | 14 +
 rtl/lfsr_core.sv | 37 +++
 rtl/lfsr_rng.sv | 102 ++++++++++
 tb/tb_lfsr_rng.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types, constants and step function for the LFSR generator
package lfsr_pkg;

    localparam int MAX_W = 32;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_DRAW = 1'b1
    } draw_state_t;

    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [7:0]  SEED_8  = 8'hE1;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [15:0] SEED_16 = 16'hACE1;

    // Operates on a MAX_W container; callers zero-extend and truncate to their width.
    function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] state,
                                                  input logic [MAX_W-1:0] taps);
        return (state >> 1) ^ (state[0] ? taps : '0);
    endfunction

endpackage

// File: rtl/lfsr_rng_if.sv
// rtl/lfsr_rng_if.sv - draw request/result port of the LFSR generator
interface lfsr_rng_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] range;
    logic             req;
    logic             busy;
    logic             valid;
    logic [OUT_W-1:0] rnd;
    logic             timeout;

    modport master (output range, req, input busy, valid, rnd, timeout);
    modport slave  (input range, req, output busy, valid, rnd, timeout);
endinterface

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Galois LFSR state register with load/step priority and zero-seed fix
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = TAPS_16,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = SEED_16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] q,
    output logic             zero_fix
);

    // An all-zero state is a lockup for the LFSR, so it is never allowed in.
    localparam logic [WIDTH-1:0] RESET_Q = (DEFAULT_SEED == '0) ? WIDTH'(1) : DEFAULT_SEED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q        <= RESET_Q;
            zero_fix <= 1'b0;
        end else if (load) begin
            if (seed == '0) begin
                q        <= WIDTH'(1);
                zero_fix <= 1'b1;
            end else begin
                q <= seed;
            end
        end else if (step) begin
            q <= WIDTH'(lfsr_step(MAX_W'(q), MAX_W'(TAPS)));
        end
    end

endmodule

// File: rtl/lfsr_rng.sv
// rtl/lfsr_rng.sv - LFSR generator with rejection-sampled bounded draw port
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH        = 16,
    parameter logic [WIDTH-1:0] TAPS         = TAPS_16,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = SEED_16,
    parameter int               OUT_W        = 8,
    parameter int               MAX_TRY      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             load,
    input  logic             en,
    output logic             zero_fix,
    output logic [WIDTH-1:0] q,
    lfsr_rng_if.slave        drw
);

    localparam int TRY_W = (MAX_TRY > 1) ? $clog2(MAX_TRY) : 1;
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRY - 1);

    draw_state_t      state, state_n;
    logic [TRY_W-1:0] try_cnt, try_n;
    logic             valid_q, valid_n;
    logic             timeout_q, timeout_n;
    logic [OUT_W-1:0] rnd_q, rnd_n;
    logic [OUT_W-1:0] cand;
    logic             accept;

    // While drawing the state steps every cycle so each attempt sees a fresh candidate.
    lfsr_core #(
        .WIDTH        (WIDTH),
        .TAPS         (TAPS),
        .DEFAULT_SEED (DEFAULT_SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .seed     (seed),
        .load     (load),
        .step     (en || (state == S_DRAW)),
        .q        (q),
        .zero_fix (zero_fix)
    );

    assign cand   = q[OUT_W-1:0];
    assign accept = (drw.range == '0) || (cand < drw.range);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            try_cnt   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            rnd_q     <= '0;
        end else begin
            state     <= state_n;
            try_cnt   <= try_n;
            valid_q   <= valid_n;
            timeout_q <= timeout_n;
            rnd_q     <= rnd_n;
        end
    end

    always_comb begin
        state_n   = state;
        try_n     = try_cnt;
        valid_n   = 1'b0;
        timeout_n = 1'b0;
        rnd_n     = rnd_q;
        case (state)
            S_IDLE: begin
                if (drw.req) begin
                    state_n = S_DRAW;
                    try_n   = '0;
                end
            end
            S_DRAW: begin
                if (accept) begin
                    rnd_n   = cand;
                    valid_n = 1'b1;
                    state_n = S_IDLE;
                end else if (try_cnt == TRY_LAST) begin
                    rnd_n     = '0;
                    valid_n   = 1'b1;
                    timeout_n = 1'b1;
                    state_n   = S_IDLE;
                end else begin
                    try_n = try_cnt + TRY_W'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign drw.busy    = (state == S_DRAW);
    assign drw.valid   = valid_q;
    assign drw.timeout = timeout_q;
    assign drw.rnd     = rnd_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// tb/tb_lfsr_rng.sv - self-checking bench for lfsr_rng against a behavioural model
module tb_lfsr_rng;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] seed;
    logic        load;
    logic        en;
    logic        zero_fix;
    logic [15:0] q;

    lfsr_rng_if #(.OUT_W(8)) drw ();

    lfsr_rng dut (
        .clk      (clk),
        .rst      (rst),
        .seed     (seed),
        .load     (load),
        .en       (en),
        .zero_fix (zero_fix),
        .q        (q),
        .drw      (drw)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: state as an integer, draw as "active + attempts used"
    int unsigned mq, mzf, m_busy, m_tries, m_valid, m_timeout, m_rnd;

    function automatic int unsigned next_state(input int unsigned s);
        return (s >> 1) ^ ((s % 2 == 1) ? 32'hB400 : 32'h0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq = 32'hACE1; mzf = 0; m_busy = 0; m_tries = 0;
            m_valid = 0; m_timeout = 0; m_rnd = 0;
        end else begin
            int unsigned cand;
            int unsigned was_busy;
            cand = mq % 256;
            was_busy = m_busy;
            m_valid = 0;
            m_timeout = 0;
            if (m_busy != 0) begin
                if (drw.range == 0 || cand < drw.range) begin
                    m_rnd = cand; m_valid = 1; m_busy = 0;
                end else if (m_tries + 1 == 16) begin
                    m_rnd = 0; m_valid = 1; m_timeout = 1; m_busy = 0;
                end else begin
                    m_tries++;
                end
            end else if (drw.req) begin
                m_busy = 1; m_tries = 0;
            end
            if (load) begin
                if (seed == 0) begin mq = 1; mzf = 1; end
                else mq = seed;
            end else if (en || was_busy != 0) begin
                mq = next_state(mq);
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("q", q, mq);
            chk("zero_fix", zero_fix, mzf);
            chk("busy", drw.busy, m_busy);
            chk("valid", drw.valid, m_valid);
            chk("timeout", drw.timeout, m_timeout);
            chk("rnd", drw.rnd, m_rnd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [15:0] s);
        load = 1'b1; seed = s;
        tick();
        load = 1'b0;
    endtask

    initial begin
        int seen_zero;
        int seen_valid;
        rst = 1'b1; seed = '0; load = 1'b0; en = 1'b0;
        drw.req = 1'b0; drw.range = 8'd0;
        repeat (2) tick();
        rst = 1'b0;

        // reset state
        chk("rst_q", q, 16'hACE1);
        chk("rst_busy", drw.busy, 0);
        chk("rst_valid", drw.valid, 0);
        chk("rst_rnd", drw.rnd, 0);
        chk("rst_timeout", drw.timeout, 0);
        chk("rst_zero_fix", zero_fix, 0);

        // step sequence and full period
        load_seed(16'hACE1);
        en = 1'b1;
        tick(); chk("step1", q, 16'hE270);
        tick(); chk("step2", q, 16'h7138);
        tick(); chk("step3", q, 16'h389C);
        seen_zero = 0;
        for (int i = 3; i < 65535; i++) begin
            tick();
            if (q == 16'h0) seen_zero = 1;
        end
        chk("period_q", q, 16'hACE1);
        chk("period_no_zero", seen_zero, 0);

        // asynchronous reset mid-cycle
        tick(); tick();
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_q", q, 16'hACE1);
        tick();
        rst = 1'b0; en = 1'b0;

        // zero seed
        load_seed(16'h0000);
        chk("zero_q", q, 16'h0001);
        chk("zero_fix_set", zero_fix, 1);
        load_seed(16'h1234);
        chk("zero_fix_sticky", zero_fix, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("zero_fix_clr", zero_fix, 0);

        // accept after one reject
        load_seed(16'hACE1);
        drw.range = 8'd200; drw.req = 1'b1;
        tick(); drw.req = 1'b0;
        tick(); chk("acc_pending", drw.valid, 0);
        tick();
        chk("acc_valid", drw.valid, 1);
        chk("acc_rnd", drw.rnd, 112);
        chk("acc_timeout", drw.timeout, 0);
        chk("acc_busy", drw.busy, 0);

        // full range accepts first candidate
        load_seed(16'hACE1);
        drw.range = 8'd0; drw.req = 1'b1;
        tick(); drw.req = 1'b0;
        tick();
        chk("full_valid", drw.valid, 1);
        chk("full_rnd", drw.rnd, 225);

        // timeout with range 1, req held during busy
        load_seed(16'hACE1);
        drw.range = 8'd1; drw.req = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("to_busy", drw.busy, 1);
            tick();
        end
        drw.req = 1'b0;
        chk("to_valid", drw.valid, 1);
        chk("to_timeout", drw.timeout, 1);
        chk("to_rnd", drw.rnd, 0);
        tick();
        chk("to_idle", drw.busy, 0);

        // load during draw
        load_seed(16'hACE1);
        drw.range = 8'd1; drw.req = 1'b1;
        tick(); drw.req = 1'b0;
        tick();
        load_seed(16'h1234);
        chk("mid_load_q", q, 16'h1234);
        seen_valid = 0;
        for (int i = 0; i < 40 && seen_valid == 0; i++) begin
            tick();
            if (drw.valid) seen_valid = 1;
        end
        chk("mid_load_done", seen_valid, 1);

        // reset during draw
        load_seed(16'hACE1);
        drw.range = 8'd1; drw.req = 1'b1;
        tick(); drw.req = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_draw_busy", drw.busy, 0);
        tick();
        rst = 1'b0;
        seen_valid = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (drw.valid) seen_valid = 1;
        end
        chk("rst_draw_novalid", seen_valid, 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drw.req = ($urandom_range(0, 3) == 0);
            en      = ($urandom_range(0, 1) == 1);
            load    = ($urandom_range(0, 31) == 0);
            seed    = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            case ($urandom_range(0, 3))
                0: drw.range = 8'd0;
                1: drw.range = 8'($urandom_range(1, 4));
                2: drw.range = 8'($urandom_range(200, 255));
                default: drw.range = 8'($urandom);
            endcase
            tick();
        end
        drw.req = 1'b0; en = 1'b0; load = 1'b0;
        repeat (20) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
